// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants, FSM states and PC-to-ROM-index conversion for instr_fetch
package fetch_pkg;

    localparam logic [15:0] ROM_BASE_DEF  = 16'hC000;
    localparam logic [15:0] RESET_VEC_DEF = 16'hFFFE;

    typedef enum logic [1:0] {
        ST_VEC   = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_t;

    // Byte PC to ROM word index; wraps modulo 2^16 for PCs below the ROM base.
    function automatic logic [15:0] pc_index(input logic [15:0] pc, input logic [15:0] base);
        logic [15:0] off;
        off = pc - base;
        return off >> 1;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - DEPTH-entry {pc,word} prefetch FIFO; flush dominates push and pop
module fetch_queue #(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [31:0]                din,
    output logic [31:0]                dout,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    // Head comes straight from storage so the decoder never sees rom_out combinationally.
    assign dout = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: reset-vector load, redirects, prefetch queue to decoder; FETCH_BOUNDS_EN adds sticky range fault
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [15:0] ROM_BASE  = ROM_BASE_DEF,
    parameter logic [15:0] RESET_VEC = RESET_VEC_DEF,
    parameter int          DEPTH     = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] rom_addr,
    output logic        rom_bw,
    input  logic [15:0] rom_out,
    input  logic        redir,
    input  logic [15:0] redir_pc,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [15:0] ins_word,
    output logic [15:0] ins_pc,
    output logic        fetch_fault
);

    localparam int            AW   = $clog2(DEPTH);
    localparam logic [AW:0]   FULL = (AW + 1)'(DEPTH);

    fetch_state_t state, state_nxt;
    logic [15:0]  fetch_pc, pc_nxt;
    logic         push, pop, flush, pop_ok;
    logic [AW:0]  count;
    logic [31:0]  head;
`ifdef FETCH_BOUNDS_EN
    logic         fault, fault_nxt;
`endif

    assign rom_addr  = pc_index(fetch_pc, ROM_BASE);
    assign rom_bw    = 1'b0;
    assign ins_valid = (count != '0);
    assign ins_pc    = head[31:16];
    assign ins_word  = head[15:0];
    assign pop_ok    = ins_valid && ins_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_VEC;
            fetch_pc <= RESET_VEC;
        end else begin
            state    <= state_nxt;
            fetch_pc <= pc_nxt;
        end
    end

    // Priority inside RUN: redirect flushes and blocks the pop, then pop, then push.
    always_comb begin
        state_nxt = state;
        pc_nxt    = fetch_pc;
        push      = 1'b0;
        pop       = 1'b0;
        flush     = 1'b0;
`ifdef FETCH_BOUNDS_EN
        fault_nxt = fault;
`endif
        case (state)
            ST_VEC: begin
                pc_nxt    = rom_out & 16'hFFFE;
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (redir) begin
                    flush  = 1'b1;
                    pc_nxt = redir_pc & 16'hFFFE;
                end else begin
                    pop = pop_ok;
                    if (count < FULL || pop_ok) begin
`ifdef FETCH_BOUNDS_EN
                        if (fetch_pc < ROM_BASE) begin
                            fault_nxt = 1'b1;
                            state_nxt = ST_FAULT;
                        end else begin
                            push   = 1'b1;
                            pc_nxt = fetch_pc + 16'd2;
                        end
`else
                        push   = 1'b1;
                        pc_nxt = fetch_pc + 16'd2;
`endif
                    end
                end
            end
            ST_FAULT: begin
                pop = pop_ok;
            end
            default: begin
                state_nxt = ST_VEC;
            end
        endcase
    end

`ifdef FETCH_BOUNDS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault <= 1'b0;
        end else begin
            fault <= fault_nxt;
        end
    end
    assign fetch_fault = fault;
`else
    assign fetch_fault = 1'b0;
`endif

    fetch_queue #(.DEPTH(DEPTH)) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   ({fetch_pc, rom_out}),
        .dout  (head),
        .count (count)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch with a queue-level reference model
module tb_instr_fetch;

    localparam int DEPTH = 2;

    logic        clk, rst, rom_bw, redir, ins_valid, ins_ready, fetch_fault;
    logic [15:0] rom_addr, rom_out, redir_pc, ins_word, ins_pc;
    logic [15:0] rom_mem [65536];

    int checks   = 0;
    int failures = 0;

    instr_fetch #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .rom_addr    (rom_addr),
        .rom_bw      (rom_bw),
        .rom_out     (rom_out),
        .redir       (redir),
        .redir_pc    (redir_pc),
        .ins_valid   (ins_valid),
        .ins_ready   (ins_ready),
        .ins_word    (ins_word),
        .ins_pc      (ins_pc),
        .fetch_fault (fetch_fault)
    );

    assign rom_out = rom_mem[rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] widx(input logic [15:0] pc);
        logic [15:0] t;
        t = pc - 16'hC000;
        return t >> 1;
    endfunction

    // Reference model: byte PC, a queue of {pc,word}, vector/fault flags.
    logic        m_vec, m_fault, m_pop, m_room;
    logic [15:0] m_pc;
    logic [31:0] mq[$];

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                m_vec   = 1'b1;
                m_fault = 1'b0;
                m_pc    = 16'hFFFE;
                mq.delete();
            end
            check("m_rom_addr", rom_addr, widx(m_pc));
            check("m_rom_bw", rom_bw, 0);
            check("m_valid", ins_valid, mq.size() != 0);
            check("m_fault", fetch_fault, m_fault);
            if (mq.size() != 0) begin
                check("m_ins_pc", ins_pc, mq[0][31:16]);
                check("m_ins_word", ins_word, mq[0][15:0]);
            end
            if (!rst) begin
                if (m_vec) begin
                    m_pc  = rom_mem[widx(16'hFFFE)] & 16'hFFFE;
                    m_vec = 1'b0;
                end else if (m_fault) begin
                    if (mq.size() != 0 && ins_ready) void'(mq.pop_front());
                end else if (redir) begin
                    mq.delete();
                    m_pc = redir_pc & 16'hFFFE;
                end else begin
                    m_pop  = (mq.size() != 0) && ins_ready;
                    m_room = (mq.size() < DEPTH) || m_pop;
                    if (m_pop) void'(mq.pop_front());
                    if (m_room) begin
`ifdef FETCH_BOUNDS_EN
                        if (m_pc < 16'hC000) begin
                            m_fault = 1'b1;
                        end else begin
                            mq.push_back({m_pc, rom_mem[widx(m_pc)]});
                            m_pc = m_pc + 16'd2;
                        end
`else
                        mq.push_back({m_pc, rom_mem[widx(m_pc)]});
                        m_pc = m_pc + 16'd2;
`endif
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) rom_mem[i] = 16'(i) ^ 16'hA5C3;
        rom_mem[16'h1FFF] = 16'hC000;
        rst       = 1'b1;
        redir     = 1'b0;
        redir_pc  = 16'h0000;
        ins_ready = 1'b0;
        #2;
        check("rst_rom_addr", rom_addr, 16'h1FFF);
        check("rst_valid", ins_valid, 0);
        check("rst_ins_pc", ins_pc, 16'h0000);
        check("rst_ins_word", ins_word, 16'h0000);
        check("rst_fault", fetch_fault, 0);
        ins_ready = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Reset vector load and streaming
        step();
        check("vec_rom_addr", rom_addr, 16'h0000);
        check("vec_valid", ins_valid, 0);
        step();
        check("first_valid", ins_valid, 1);
        check("first_pc", ins_pc, 16'hC000);
        check("first_word", ins_word, 16'hA5C3);
        step();
        check("second_pc", ins_pc, 16'hC002);
        step();
        check("third_pc", ins_pc, 16'hC004);

        // Backpressure from a fresh start at 0xC000
        ins_ready = 1'b0;
        redir     = 1'b1;
        redir_pc  = 16'hC000;
        step();
        redir = 1'b0;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_rom_addr", rom_addr, 16'h0002);
            check("bp_head", ins_pc, 16'hC000);
        end
        ins_ready = 1'b1;
        step();
        check("rel_pc1", ins_pc, 16'hC002);
        step();
        check("rel_pc2", ins_pc, 16'hC004);
        step();
        check("rel_pc3", ins_pc, 16'hC006);

        // Redirect in the same cycle as a would-be pop
        redir    = 1'b1;
        redir_pc = 16'hC101;
        step();
        redir = 1'b0;
        check("redir_bubble", ins_valid, 0);
        step();
        check("redir_valid", ins_valid, 1);
        check("redir_pc", ins_pc, 16'hC100);
        check("redir_word", ins_word, 16'hA543);

        // Asynchronous reset with a full queue
        ins_ready = 1'b0;
        step();
        check("full_valid", ins_valid, 1);
        rst = 1'b1;
        #1;
        check("async_valid", ins_valid, 0);
        check("async_pc", ins_pc, 16'h0000);
        check("async_rom_addr", rom_addr, 16'h1FFF);
        step();
        rst       = 1'b0;
        redir     = 1'b1;
        redir_pc  = 16'h4444;
        ins_ready = 1'b1;
        step();
        redir = 1'b0;
        check("vec_wins_rom_addr", rom_addr, 16'h0000);
        step();
        check("vec_wins_pc", ins_pc, 16'hC000);

        // Top-of-memory wrap
        redir    = 1'b1;
        redir_pc = 16'hFFFC;
        step();
        redir = 1'b0;
        check("wrap_bubble", ins_valid, 0);
        step();
        check("wrap_pc0", ins_pc, 16'hFFFC);
        check("wrap_word0", ins_word, 16'hBA3D);
        step();
        check("wrap_pc1", ins_pc, 16'hFFFE);
        check("wrap_word1", ins_word, 16'hC000);
        step();
`ifdef FETCH_BOUNDS_EN
        check("wrap_fault", fetch_fault, 1);
        check("wrap_fault_valid", ins_valid, 0);
`else
        check("wrap_pc2", ins_pc, 16'h0000);
        check("wrap_word2", ins_word, 16'h85C3);
`endif
        redir    = 1'b1;
        redir_pc = 16'hC000;
        step();
        redir = 1'b0;
        step();
        step();
        step();
`ifdef FETCH_BOUNDS_EN
        check("fault_sticky", fetch_fault, 1);
        check("fault_no_push", ins_valid, 0);
`else
        check("post_wrap_pc", ins_pc, 16'hC004);
`endif
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
